// File: rtl/adc_clock_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : adc_clock_scheduler
// Purpose  : Runtime-programmable ADC sample-clock generator. Divides clock_in
//            by a software-selected divisor. Start, stop and divisor changes
//            take effect only on full-period boundaries, so clock_out never
//            produces a runt pulse or glitch.
// Ports    : clock_in      - fabric clock, all logic on rising edge
//            reset_n       - synchronous active-low reset
//            enable        - 1 = generate clock, 0 = stop at next period end
//            div_value     - requested divisor
//            div_valid     - divisor request valid
//            div_ready     - a divisor request can be accepted
//            div_error     - 1-cycle pulse, request below MIN_DIV rejected
//            clock_out     - divided clock, registered
//            active        - high whenever the scheduler is not stopped
//            period_strobe - 1-cycle pulse at each period terminal count
//            current_div   - divisor currently in effect
// Revision : 1.0 - initial release
// ============================================================================
module adc_clock_scheduler #(
    parameter int CNT_W       = 28,
    parameter int DEFAULT_DIV = 50_000_000,
    parameter int MIN_DIV     = 2
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [CNT_W-1:0] div_value,
    input  logic             div_valid,
    output logic             div_ready,
    output logic             div_error,
    output logic             clock_out,
    output logic             active,
    output logic             period_strobe,
    output logic [CNT_W-1:0] current_div
);

    localparam logic [CNT_W-1:0] c_ONE         = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_MIN_DIV     = CNT_W'(MIN_DIV);
    localparam logic [CNT_W-1:0] c_DEFAULT_DIV = CNT_W'(DEFAULT_DIV);

    typedef enum logic [1:0] {
        ST_STOP     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_counter;
    logic [CNT_W-1:0] r_current_div;
    logic [CNT_W-1:0] r_pending;
    logic             r_pending_full;
    logic             r_clock_out;
    logic             r_div_error;

    logic             w_counting;
    logic             w_tc;
    logic             w_accept;
    logic             w_reject;
    logic             w_apply;
    logic [CNT_W-1:0] w_half;

    assign w_counting = (r_state != ST_STOP);
    assign w_tc       = w_counting && (r_counter == (r_current_div - c_ONE));
    assign w_half     = r_current_div >> 1;

    // A request is only taken while the single pending slot is empty.
    assign w_accept = div_valid && !r_pending_full;
    assign w_reject = w_accept && (div_value < c_MIN_DIV);

    // Pending divisor goes live immediately when stopped, otherwise only on
    // the terminal count so the old period (including its low phase) finishes.
    // Because the slot fills on an edge, a request taken during a TC cycle
    // is not visible until the following TC.
    assign w_apply = r_pending_full && (!w_counting || w_tc);

    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            r_state <= ST_STOP;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_STOP: begin
                if (enable) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // Dropping enable on the final cycle of a period ends it there.
                if (!enable) begin
                    w_state_next = w_tc ? ST_STOP : ST_STOPPING;
                end
            end
            ST_STOPPING: begin
                if (enable) begin
                    w_state_next = ST_RUN;
                end else if (w_tc) begin
                    w_state_next = ST_STOP;
                end
            end
            default: begin
                w_state_next = ST_STOP;
            end
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            r_counter      <= '0;
            r_current_div  <= c_DEFAULT_DIV;
            r_pending      <= '0;
            r_pending_full <= 1'b0;
            r_clock_out    <= 1'b0;
            r_div_error    <= 1'b0;
        end else begin
            r_div_error <= w_reject;

            // Accept and apply are mutually exclusive: accept needs an empty
            // slot, apply needs a full one.
            if (w_accept && !w_reject) begin
                r_pending      <= div_value;
                r_pending_full <= 1'b1;
            end else if (w_apply) begin
                r_current_div  <= r_pending;
                r_pending_full <= 1'b0;
            end

            if (!w_counting || w_tc) begin
                r_counter <= '0;
            end else begin
                r_counter <= r_counter + c_ONE;
            end

            // One cycle behind the counter: high for floor(div/2) cycles.
            r_clock_out <= w_counting && (r_counter < w_half);
        end
    end

    assign div_ready     = !r_pending_full;
    assign div_error     = r_div_error;
    assign clock_out     = r_clock_out;
    assign active        = w_counting;
    assign period_strobe = w_tc;
    assign current_div   = r_current_div;

endmodule
`default_nettype wire

// File: tb/tb_adc_clock_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_clock_scheduler
// Purpose  : Directed self-checking bench for adc_clock_scheduler, run with
//            DEFAULT_DIV=10 and an 8-bit counter. Expected waveforms are hand
//            written bit patterns indexed by the counter value preceding each
//            sampled edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_clock_scheduler;

    localparam int W = 8;

    logic         clock_in;
    logic         reset_n;
    logic         enable;
    logic [W-1:0] div_value;
    logic         div_valid;
    logic         div_ready;
    logic         div_error;
    logic         clock_out;
    logic         active;
    logic         period_strobe;
    logic [W-1:0] current_div;

    int total;
    int bad;

    // Bit c holds the expected clock_out after an edge where the counter was c.
    logic [9:0] p10;
    logic [6:0] p7;
    logic [3:0] p4;

    adc_clock_scheduler #(
        .CNT_W       (W),
        .DEFAULT_DIV (10),
        .MIN_DIV     (2)
    ) dut (
        .clock_in      (clock_in),
        .reset_n       (reset_n),
        .enable        (enable),
        .div_value     (div_value),
        .div_valid     (div_valid),
        .div_ready     (div_ready),
        .div_error     (div_error),
        .clock_out     (clock_out),
        .active        (active),
        .period_strobe (period_strobe),
        .current_div   (current_div)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    // Advance one rising edge, then return at the following falling edge.
    task automatic tick();
        @(posedge clock_in);
        @(negedge clock_in);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        total++; if (clock_out !== 1'b0) begin bad++; $display("FAIL reset_clk: got %b want 0", clock_out); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL reset_active: got %b want 0", active); end
        total++; if (div_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", div_ready); end
        total++; if (div_error !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", div_error); end
        total++; if (period_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe: got %b want 0", period_strobe); end
        total++; if (current_div !== 8'd10) begin bad++; $display("FAIL reset_div: got %0d want 10", current_div); end
        reset_n = 1'b1;
        tick();
        total++; if (active !== 1'b0) begin bad++; $display("FAIL idle_active: got %b want 0", active); end
    endtask

    // Ends with counter at 0, div 10.
    task automatic test_run_default();
        enable = 1'b1;
        tick();
        total++; if (active !== 1'b1) begin bad++; $display("FAIL start_active: got %b want 1", active); end
        total++; if (clock_out !== 1'b0) begin bad++; $display("FAIL start_clk: got %b want 0", clock_out); end
        for (int k = 1; k <= 20; k++) begin
            tick();
            total++;
            if (clock_out !== p10[(k - 1) % 10]) begin
                bad++; $display("FAIL run_clk[%0d]: got %b want %b", k, clock_out, p10[(k - 1) % 10]);
            end
            total++;
            if (period_strobe !== ((k % 10) == 9)) begin
                bad++; $display("FAIL run_strobe[%0d]: got %b want %b", k, period_strobe, ((k % 10) == 9));
            end
        end
    endtask

    // Ends with counter at 0, div 4.
    task automatic test_div_change();
        tick();
        tick();
        div_valid = 1'b1;
        div_value = 8'd4;
        tick();
        total++; if (div_ready !== 1'b0) begin bad++; $display("FAIL chg_ready_low: got %b want 0", div_ready); end
        total++; if (current_div !== 8'd10) begin bad++; $display("FAIL chg_div_hold: got %0d want 10", current_div); end
        div_value = 8'd9;  // must be ignored while the slot is full
        for (int j = 1; j <= 6; j++) begin
            tick();
            total++;
            if (clock_out !== p10[2 + j]) begin
                bad++; $display("FAIL chg_old_clk[%0d]: got %b want %b", j, clock_out, p10[2 + j]);
            end
            total++;
            if (div_ready !== 1'b0) begin bad++; $display("FAIL chg_ready_wait[%0d]: got %b want 0", j, div_ready); end
        end
        total++; if (period_strobe !== 1'b1) begin bad++; $display("FAIL chg_tc_strobe: got %b want 1", period_strobe); end
        div_valid = 1'b0;
        tick();
        total++; if (current_div !== 8'd4) begin bad++; $display("FAIL chg_div_new: got %0d want 4", current_div); end
        total++; if (div_ready !== 1'b1) begin bad++; $display("FAIL chg_ready_back: got %b want 1", div_ready); end
        total++; if (clock_out !== 1'b0) begin bad++; $display("FAIL chg_switch_clk: got %b want 0", clock_out); end
        for (int m = 1; m <= 8; m++) begin
            tick();
            total++;
            if (clock_out !== p4[(m - 1) % 4]) begin
                bad++; $display("FAIL chg_new_clk[%0d]: got %b want %b", m, clock_out, p4[(m - 1) % 4]);
            end
            total++;
            if (period_strobe !== ((m % 4) == 3)) begin
                bad++; $display("FAIL chg_new_strobe[%0d]: got %b want %b", m, period_strobe, ((m % 4) == 3));
            end
        end
        total++; if (current_div !== 8'd4) begin bad++; $display("FAIL chg_no_second: got %0d want 4", current_div); end
        total++; if (div_ready !== 1'b1) begin bad++; $display("FAIL chg_ready_idle: got %b want 1", div_ready); end
    endtask

    // Starts and ends with counter at 0, div 4.
    task automatic test_div_error();
        div_valid = 1'b1;
        div_value = 8'd1;
        tick();
        total++; if (div_error !== 1'b1) begin bad++; $display("FAIL err1_pulse: got %b want 1", div_error); end
        total++; if (div_ready !== 1'b1) begin bad++; $display("FAIL err1_ready: got %b want 1", div_ready); end
        total++; if (clock_out !== 1'b1) begin bad++; $display("FAIL err1_clk: got %b want 1", clock_out); end
        div_valid = 1'b0;
        tick();
        total++; if (div_error !== 1'b0) begin bad++; $display("FAIL err1_end: got %b want 0", div_error); end
        div_valid = 1'b1;
        div_value = 8'd0;
        tick();
        total++; if (div_error !== 1'b1) begin bad++; $display("FAIL err0_pulse: got %b want 1", div_error); end
        total++; if (current_div !== 8'd4) begin bad++; $display("FAIL err0_div: got %0d want 4", current_div); end
        div_valid = 1'b0;
        tick();
        total++; if (div_error !== 1'b0) begin bad++; $display("FAIL err0_end: got %b want 0", div_error); end
        total++; if (div_ready !== 1'b1) begin bad++; $display("FAIL err_ready: got %b want 1", div_ready); end
        total++; if (current_div !== 8'd4) begin bad++; $display("FAIL err_div: got %0d want 4", current_div); end
        total++; if (clock_out !== 1'b0) begin bad++; $display("FAIL err_clk: got %b want 0", clock_out); end
    endtask

    // From counter 0 of any running divisor, move back to div 10 at its TC.
    task automatic restore_div10();
        int n;
        div_valid = 1'b1;
        div_value = 8'd10;
        tick();
        div_valid = 1'b0;
        n = 0;
        while (current_div !== 8'd10 && n < 20) begin
            tick();
            n++;
        end
        total++; if (current_div !== 8'd10) begin bad++; $display("FAIL restore_div: got %0d want 10", current_div); end
    endtask

    // Starts and ends with counter at 0, div 7.
    task automatic test_accept_at_tc();
        for (int j = 0; j < 9; j++) tick();
        total++; if (period_strobe !== 1'b1) begin bad++; $display("FAIL tc_strobe: got %b want 1", period_strobe); end
        div_valid = 1'b1;
        div_value = 8'd7;
        tick();
        div_valid = 1'b0;
        total++; if (current_div !== 8'd10) begin bad++; $display("FAIL tc_not_applied: got %0d want 10", current_div); end
        total++; if (div_ready !== 1'b0) begin bad++; $display("FAIL tc_ready: got %b want 0", div_ready); end
        for (int m = 1; m <= 10; m++) begin
            tick();
            total++;
            if (clock_out !== p10[m - 1]) begin
                bad++; $display("FAIL tc_old_clk[%0d]: got %b want %b", m, clock_out, p10[m - 1]);
            end
        end
        total++; if (current_div !== 8'd7) begin bad++; $display("FAIL tc_div7: got %0d want 7", current_div); end
        total++; if (div_ready !== 1'b1) begin bad++; $display("FAIL tc_ready_back: got %b want 1", div_ready); end
        for (int m = 1; m <= 7; m++) begin
            tick();
            total++;
            if (clock_out !== p7[m - 1]) begin
                bad++; $display("FAIL tc_new_clk[%0d]: got %b want %b", m, clock_out, p7[m - 1]);
            end
            total++;
            if (period_strobe !== (m == 6)) begin
                bad++; $display("FAIL tc_new_strobe[%0d]: got %b want %b", m, period_strobe, (m == 6));
            end
        end
    endtask

    // Starts and ends with counter at 0, div 10.
    task automatic test_stop_restart();
        tick();
        tick();
        enable = 1'b0;
        for (int j = 1; j <= 7; j++) begin
            tick();
            total++;
            if (clock_out !== p10[1 + j]) begin
                bad++; $display("FAIL stop_clk[%0d]: got %b want %b", j, clock_out, p10[1 + j]);
            end
            total++;
            if (active !== 1'b1) begin bad++; $display("FAIL stop_active[%0d]: got %b want 1", j, active); end
        end
        total++; if (period_strobe !== 1'b1) begin bad++; $display("FAIL stop_last_tc: got %b want 1", period_strobe); end
        tick();
        total++; if (clock_out !== 1'b0) begin bad++; $display("FAIL stop_end_clk: got %b want 0", clock_out); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL stop_end_active: got %b want 0", active); end
        tick();
        tick();
        total++; if (clock_out !== 1'b0) begin bad++; $display("FAIL stopped_clk: got %b want 0", clock_out); end
        total++; if (period_strobe !== 1'b0) begin bad++; $display("FAIL stopped_strobe: got %b want 0", period_strobe); end
        enable = 1'b1;
        tick();
        total++; if (active !== 1'b1) begin bad++; $display("FAIL restart_active: got %b want 1", active); end
        tick();
        tick();
        enable = 1'b0;
        for (int j = 0; j < 4; j++) tick();
        enable = 1'b1;
        for (int j = 1; j <= 14; j++) begin
            tick();
            total++;
            if (clock_out !== p10[(5 + j) % 10]) begin
                bad++; $display("FAIL resume_clk[%0d]: got %b want %b", j, clock_out, p10[(5 + j) % 10]);
            end
            total++;
            if (active !== 1'b1) begin bad++; $display("FAIL resume_active[%0d]: got %b want 1", j, active); end
        end
    endtask

    task automatic test_reset_pending();
        tick();
        tick();
        div_valid = 1'b1;
        div_value = 8'd6;
        tick();
        div_valid = 1'b0;
        total++; if (div_ready !== 1'b0) begin bad++; $display("FAIL rp_full: got %b want 0", div_ready); end
        enable  = 1'b0;
        reset_n = 1'b0;
        tick();
        total++; if (clock_out !== 1'b0) begin bad++; $display("FAIL rp_clk: got %b want 0", clock_out); end
        total++; if (current_div !== 8'd10) begin bad++; $display("FAIL rp_div: got %0d want 10", current_div); end
        total++; if (div_ready !== 1'b1) begin bad++; $display("FAIL rp_ready: got %b want 1", div_ready); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL rp_active: got %b want 0", active); end
        reset_n = 1'b1;
        tick();
        tick();
        total++; if (current_div !== 8'd10) begin bad++; $display("FAIL rp_discard: got %0d want 10", current_div); end
        total++; if (div_ready !== 1'b1) begin bad++; $display("FAIL rp_ready_after: got %b want 1", div_ready); end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        p10       = 10'b0000011111;
        p7        = 7'b0000111;
        p4        = 4'b0011;
        reset_n   = 1'b0;
        enable    = 1'b0;
        div_valid = 1'b0;
        div_value = '0;

        test_reset();
        test_run_default();
        test_div_change();
        test_div_error();
        restore_div10();
        test_accept_at_tc();
        restore_div10();
        test_stop_restart();
        test_reset_pending();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
